// File: rtl/gpu_pkg.sv
// Shared types for the kernel dispatcher: top-level launch FSM and per-core slot FSM.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } dispatch_state_t;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2
  } slot_state_t;

endpackage

// File: rtl/kernel_dispatch_if.sv
// Launch-control and core-array signals of the kernel dispatcher.
interface kernel_dispatch_if #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 16,
  parameter int BLOCK_ID_BITS     = 8
);
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

  logic                                    start;
  logic                                    abort;
  logic [THREAD_COUNT_BITS-1:0]            thread_count;
  logic [NUM_CORES-1:0]                    core_done;
  logic [NUM_CORES-1:0]                    core_start;
  logic [NUM_CORES-1:0]                    core_reset;
  logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0] core_block_id;
  logic [NUM_CORES-1:0][TCW-1:0]           core_thread_count;
  logic                                    busy;
  logic                                    done;
  logic                                    error;
  logic [THREAD_COUNT_BITS-1:0]            blocks_dispatched;
  logic [THREAD_COUNT_BITS-1:0]            blocks_completed;

  modport master (
    output start, abort, thread_count, core_done,
    input  core_start, core_reset, core_block_id, core_thread_count,
    input  busy, done, error, blocks_dispatched, blocks_completed
  );

  modport slave (
    input  start, abort, thread_count, core_done,
    output core_start, core_reset, core_block_id, core_thread_count,
    output busy, done, error, blocks_dispatched, blocks_completed
  );

endinterface

// File: rtl/dispatch_core_slot.sv
// One core slot: FREE -> RST (1-cycle core_reset) -> RUN (core_start held) -> FREE on core_done.
module dispatch_core_slot
  import gpu_pkg::*;
#(
  parameter int BLOCK_ID_BITS = 8,
  parameter int TCW           = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue,
  input  logic                     abort,
  input  logic                     core_done,
  input  logic [BLOCK_ID_BITS-1:0] issue_block_id,
  input  logic [TCW-1:0]           issue_thread_count,
  output logic                     free,
  output logic                     retire,
  output logic                     core_start,
  output logic                     core_reset,
  output logic [BLOCK_ID_BITS-1:0] block_id,
  output logic [TCW-1:0]           thread_count
);

  slot_state_t              state_q, state_d;
  logic                     core_reset_q, core_reset_d;
  logic [BLOCK_ID_BITS-1:0] block_id_q, block_id_d;
  logic [TCW-1:0]           thread_count_q, thread_count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= FREE;
      core_reset_q   <= 1'b0;
      block_id_q     <= '0;
      thread_count_q <= '0;
    end else begin
      state_q        <= state_d;
      core_reset_q   <= core_reset_d;
      block_id_q     <= block_id_d;
      thread_count_q <= thread_count_d;
    end
  end

  // Abort wins over everything, so a core_done in the abort cycle never retires.
  always_comb begin
    state_d        = state_q;
    core_reset_d   = 1'b0;
    block_id_d     = block_id_q;
    thread_count_d = thread_count_q;
    retire         = 1'b0;
    if (abort) begin
      state_d      = FREE;
      core_reset_d = 1'b1;
    end else begin
      case (state_q)
        FREE: if (issue) begin
          state_d        = RST;
          core_reset_d   = 1'b1;
          block_id_d     = issue_block_id;
          thread_count_d = issue_thread_count;
        end
        RST:  state_d = RUN;
        RUN:  if (core_done) begin
          state_d = FREE;
          retire  = 1'b1;
        end
        default: state_d = FREE;
      endcase
    end
  end

  assign free         = (state_q == FREE);
  assign core_start   = (state_q == RUN);
  assign core_reset   = core_reset_q;
  assign block_id     = block_id_q;
  assign thread_count = thread_count_q;

endmodule

// File: rtl/kernel_dispatch.sv
// Splits a kernel launch into blocks and issues them to the lowest free core, one per cycle.
module kernel_dispatch
  import gpu_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 16,
  parameter int BLOCK_ID_BITS     = 8
) (
  input logic             clk,
  input logic             reset,
  kernel_dispatch_if.slave bus
);

  localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int TCW      = LOG2_TPB + 1;
  // One extra bit keeps block counts exact even when total == 2**THREAD_COUNT_BITS.
  localparam int CW       = THREAD_COUNT_BITS + 1;
  localparam logic [CW-1:0] MAX_BLOCKS = CW'(1) << BLOCK_ID_BITS;
  localparam logic [CW-1:0] TPB_M1     = CW'(THREADS_PER_BLOCK - 1);

  if (BLOCK_ID_BITS > THREAD_COUNT_BITS) begin : g_chk_bits
    $error("kernel_dispatch: BLOCK_ID_BITS must not exceed THREAD_COUNT_BITS");
  end
  if ((THREADS_PER_BLOCK < 1) || ((THREADS_PER_BLOCK & (THREADS_PER_BLOCK - 1)) != 0)) begin : g_chk_tpb
    $error("kernel_dispatch: THREADS_PER_BLOCK must be a power of two");
  end

  dispatch_state_t              state_q, state_d;
  logic                         start_q;
  logic [THREAD_COUNT_BITS-1:0] tc_q, tc_d;
  logic [CW-1:0]                total_q, total_d;
  logic [CW-1:0]                disp_q, disp_d;
  logic [CW-1:0]                comp_q, comp_d;
  logic                         done_q, done_d;
  logic                         error_q, error_d;

  logic                         start_edge, abort_v, issue_any;
  logic [CW-1:0]                new_total, retire_cnt;
  logic [TCW-1:0]               issue_tc;
  logic [NUM_CORES-1:0]         slot_free, slot_retire, issue;
  logic [NUM_CORES-1:0]         core_start_w, core_reset_w;
  logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0] block_id_w;
  logic [NUM_CORES-1:0][TCW-1:0]           thread_count_w;

  assign start_edge = bus.start & ~start_q;
  assign abort_v    = bus.abort & (state_q != IDLE);
  assign new_total  = (CW'(bus.thread_count) + TPB_M1) >> LOG2_TPB;

  // Only the last block can be partial; it carries tc - id*TPB threads.
  assign issue_tc = (disp_q == total_q - CW'(1))
                  ? TCW'(CW'(tc_q) - (disp_q << LOG2_TPB))
                  : TCW'(THREADS_PER_BLOCK);

  always_comb begin
    issue     = '0;
    issue_any = 1'b0;
    if ((state_q == DISPATCH) && !bus.abort && (disp_q < total_q)) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (slot_free[i] && !issue_any) begin
          issue[i]  = 1'b1;
          issue_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) retire_cnt = retire_cnt + CW'(slot_retire[i]);
  end

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    total_d = total_q;
    disp_d  = disp_q;
    comp_d  = comp_q;
    done_d  = done_q;
    error_d = error_q;
    if (abort_v) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      comp_d = comp_q + retire_cnt;
      case (state_q)
        IDLE, DONE: if (start_edge) begin
          tc_d    = bus.thread_count;
          total_d = new_total;
          disp_d  = '0;
          comp_d  = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          if (bus.thread_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (new_total > MAX_BLOCKS) begin
            state_d = IDLE;
            error_d = 1'b1;
          end else begin
            state_d = DISPATCH;
          end
        end
        DISPATCH: if (issue_any) begin
          disp_d = disp_q + CW'(1);
          if (disp_q + CW'(1) == total_q) state_d = DRAIN;
        end
        DRAIN: if (comp_q == total_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      tc_q    <= '0;
      total_q <= '0;
      disp_q  <= '0;
      comp_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      tc_q    <= tc_d;
      total_q <= total_d;
      disp_q  <= disp_d;
      comp_q  <= comp_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    dispatch_core_slot #(
      .BLOCK_ID_BITS(BLOCK_ID_BITS),
      .TCW          (TCW)
    ) u_slot (
      .clk               (clk),
      .reset             (reset),
      .issue             (issue[g]),
      .abort             (abort_v),
      .core_done         (bus.core_done[g]),
      .issue_block_id    (disp_q[BLOCK_ID_BITS-1:0]),
      .issue_thread_count(issue_tc),
      .free              (slot_free[g]),
      .retire            (slot_retire[g]),
      .core_start        (core_start_w[g]),
      .core_reset        (core_reset_w[g]),
      .block_id          (block_id_w[g]),
      .thread_count      (thread_count_w[g])
    );
  end

  assign bus.core_start        = core_start_w;
  assign bus.core_reset        = core_reset_w;
  assign bus.core_block_id     = block_id_w;
  assign bus.core_thread_count = thread_count_w;
  assign bus.busy              = (state_q == DISPATCH) || (state_q == DRAIN);
  assign bus.done              = done_q;
  assign bus.error             = error_q;
  assign bus.blocks_dispatched = disp_q[THREAD_COUNT_BITS-1:0];
  assign bus.blocks_completed  = comp_q[THREAD_COUNT_BITS-1:0];

endmodule

// File: tb/tb_kernel_dispatch.sv
// Bench for kernel_dispatch: random core latencies against a block-level launch model.
module tb_kernel_dispatch;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TCB = 16;
  localparam int BIB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kernel_dispatch_if #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB),
                       .THREAD_COUNT_BITS(TCB), .BLOCK_ID_BITS(BIB)) bus ();

  kernel_dispatch #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB),
                    .THREAD_COUNT_BITS(TCB), .BLOCK_ID_BITS(BIB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int issued_core[4];
  int issued_tc[4];
  int n_issued;

  // Launch tc threads and play the core array: each core finishes its block after a
  // fixed (d>=0) or random (d<0) number of running cycles. Checks every issued block
  // against ceil-division block arithmetic and the final counters.
  task automatic run_launch(input int tc, input int d0, input int d1,
                            input bit chk_lat, input bit poke, input string nm);
    int tot, cyc, id, dl, exp_tc;
    int timer[NC];
    bit seen[4];
    bit fin;
    logic [4:0] lat_exp;
    tot = (tc + TPB - 1) / TPB;
    n_issued = 0;
    for (int i = 0; i < 4; i++) begin seen[i] = 1'b0; issued_core[i] = -1; issued_tc[i] = -1; end
    for (int i = 0; i < NC; i++) timer[i] = 0;
    @(negedge clk);
    bus.thread_count = TCB'(tc);
    bus.start = 1'b1;
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.core_done = '0;
      if (poke && cyc == 3) begin
        bus.start = 1'b1;
        bus.thread_count = TCB'(1);
      end else begin
        bus.start = 1'b0;
      end
      if (chk_lat && cyc <= 3) begin
        lat_exp = (cyc == 1) ? 5'b10000 : (cyc == 2) ? 5'b10100 : 5'b11001;
        checks++;
        if ({bus.busy, bus.core_reset, bus.core_start} !== lat_exp) begin
          errors++;
          $display("FAIL %s latency cyc%0d: {busy,core_reset,core_start}=%b need %b",
                   nm, cyc, {bus.busy, bus.core_reset, bus.core_start}, lat_exp);
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (bus.core_reset[i]) begin
          id = int'(bus.core_block_id[i]);
          checks++;
          if (id >= tot || seen[id]) begin
            errors++;
            $display("FAIL %s issue_id: core %0d got block %0d, need unissued id below %0d", nm, i, id, tot);
          end else begin
            seen[id] = 1'b1;
            issued_core[id] = i;
            issued_tc[id] = int'(bus.core_thread_count[i]);
            n_issued++;
            exp_tc = (tc - id * TPB < TPB) ? tc - id * TPB : TPB;
            checks++;
            if (issued_tc[id] != exp_tc) begin
              errors++;
              $display("FAIL %s block_threads: block %0d got %0d need %0d", nm, id, issued_tc[id], exp_tc);
            end
          end
          dl = (i == 0) ? d0 : d1;
          timer[i] = (dl < 0) ? int'($urandom_range(0, 4)) : dl;
        end else if (bus.core_start[i]) begin
          if (timer[i] == 0) bus.core_done[i] = 1'b1;
          else timer[i]--;
        end
      end
      if (bus.done) fin = 1'b1;
    end
    bus.core_done = '0;
    checks++;
    if (!fin) begin errors++; $display("FAIL %s timeout: done=%b need 1 within 300 cycles", nm, bus.done); end
    checks++;
    if (bus.blocks_completed !== TCB'(tot)) begin
      errors++; $display("FAIL %s completed: got %0d need %0d", nm, bus.blocks_completed, tot);
    end
    checks++;
    if (bus.blocks_dispatched !== TCB'(tot)) begin
      errors++; $display("FAIL %s dispatched: got %0d need %0d", nm, bus.blocks_dispatched, tot);
    end
    checks++;
    if (n_issued != tot) begin errors++; $display("FAIL %s issued: got %0d need %0d", nm, n_issued, tot); end
    checks++;
    if ({bus.busy, bus.error} !== 2'b00) begin
      errors++; $display("FAIL %s end_flags: {busy,error}=%b need 00", nm, {bus.busy, bus.error});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.thread_count = '0; bus.core_done = '0;
    #12;
    checks++;
    if ({bus.core_start, bus.core_reset, bus.core_block_id, bus.core_thread_count, bus.busy,
         bus.done, bus.error, bus.blocks_dispatched, bus.blocks_completed} !== '0) begin
      errors++; $display("FAIL reset_state: outputs not all zero, core_start=%b busy=%b done=%b",
                         bus.core_start, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_zero();
    logic [2*NC-1:0] seen_core;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_pre_done: got %b need 0", bus.done); end
    bus.thread_count = '0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      errors++; $display("FAIL zero_done: {done,busy}=%b need 10", {bus.done, bus.busy});
    end
    seen_core = '0;
    repeat (5) begin
      @(negedge clk);
      seen_core = seen_core | {bus.core_reset, bus.core_start};
    end
    checks++;
    if (seen_core !== '0) begin errors++; $display("FAIL zero_core_quiet: got %b need 0", seen_core); end
  endtask

  task automatic test_two_blocks();
    run_launch(8, 1, 2, 1'b1, 1'b0, "tc8");
    checks++;
    if (issued_core[0] != 0 || issued_core[1] != 1) begin
      errors++; $display("FAIL tc8_cores: blocks 0,1 on cores %0d,%0d need 0,1", issued_core[0], issued_core[1]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      errors++; $display("FAIL tc8_done_hold: {done,busy}=%b need 10", {bus.done, bus.busy});
    end
  endtask

  task automatic test_partial();
    run_launch(10, 3, 0, 1'b0, 1'b0, "tc10");
    checks++;
    if (issued_core[2] != 1 || issued_tc[2] != 2) begin
      errors++; $display("FAIL tc10_block2: core %0d threads %0d need core 1 threads 2", issued_core[2], issued_tc[2]);
    end
  endtask

  task automatic test_error(input int tc);
    logic [2*NC-1:0] seen_core;
    @(negedge clk);
    bus.thread_count = TCB'(tc); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.error, bus.busy, bus.done} !== 3'b100) begin
      errors++; $display("FAIL error_tc%0d: {error,busy,done}=%b need 100", tc, {bus.error, bus.busy, bus.done});
    end
    seen_core = '0;
    repeat (4) begin
      @(negedge clk);
      seen_core = seen_core | {bus.core_reset, bus.core_start};
    end
    checks++;
    if (seen_core !== '0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL error_quiet_tc%0d: core activity %b busy %b need 0", tc, seen_core, bus.busy);
    end
  endtask

  task automatic test_abort();
    bit up;
    @(negedge clk);
    bus.thread_count = TCB'(16); bus.start = 1'b1;
    up = 1'b0;
    for (int c = 0; c < 20 && !up; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.core_start === 2'b11) up = 1'b1;
    end
    checks++;
    if (!up) begin errors++; $display("FAIL abort_setup: core_start=%b need 11", bus.core_start); end
    bus.abort = 1'b1; bus.core_done = 2'b01;
    @(negedge clk);
    bus.abort = 1'b0; bus.core_done = '0;
    checks++;
    if ({bus.core_reset, bus.core_start, bus.busy, bus.done} !== 6'b110000) begin
      errors++; $display("FAIL abort_cycle: {core_reset,core_start,busy,done}=%b need 110000",
                         {bus.core_reset, bus.core_start, bus.busy, bus.done});
    end
    checks++;
    if (bus.blocks_completed !== TCB'(0) || bus.blocks_dispatched !== TCB'(2)) begin
      errors++; $display("FAIL abort_counters: completed %0d dispatched %0d need 0 and 2",
                         bus.blocks_completed, bus.blocks_dispatched);
    end
    @(negedge clk);
    checks++;
    if ({bus.core_reset, bus.core_start, bus.busy} !== 5'b00000) begin
      errors++; $display("FAIL abort_after: {core_reset,core_start,busy}=%b need 00000",
                         {bus.core_reset, bus.core_start, bus.busy});
    end
    run_launch(4, 1, 1, 1'b0, 1'b0, "abort_relaunch");
  endtask

  task automatic test_random();
    int tc;
    for (int k = 0; k < 8; k++) begin
      tc = (k == 0) ? 16 : (k == 1) ? 13 : int'($urandom_range(1, 16));
      run_launch(tc, -1, -1, 1'b0, 1'b0, "rand");
    end
    for (int k = 0; k < 3; k++) test_error(int'($urandom_range(17, 1000)));
  endtask

  task automatic test_back_to_back();
    run_launch(16, 2, 2, 1'b0, 1'b1, "busy_start");
    run_launch(12, 0, 0, 1'b0, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid();
    bit up;
    @(negedge clk);
    bus.thread_count = TCB'(8); bus.start = 1'b1;
    up = 1'b0;
    for (int c = 0; c < 20 && !up; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.core_start === 2'b11) up = 1'b1;
    end
    checks++;
    if (!up || bus.busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid_setup: core_start=%b busy=%b need 11 and 1", bus.core_start, bus.busy);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({bus.core_start, bus.core_reset, bus.core_block_id, bus.core_thread_count, bus.busy,
         bus.done, bus.error, bus.blocks_dispatched, bus.blocks_completed} !== '0) begin
      errors++; $display("FAIL reset_mid_async: core_start=%b busy=%b dispatched=%0d need all zero",
                         bus.core_start, bus.busy, bus.blocks_dispatched);
    end
    @(negedge clk);
    reset = 1'b1;
    run_launch(4, 0, 0, 1'b0, 1'b0, "post_reset");
    checks++;
    if (issued_core[0] != 0) begin
      errors++; $display("FAIL post_reset_core: block 0 on core %0d need 0", issued_core[0]);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_two_blocks();
    test_partial();
    test_error(17);
    run_launch(4, 0, 1, 1'b0, 1'b0, "after_error");
    test_abort();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
